velocity_table: RTL and testbench



---
 rtl/velocity_table.sv | 161 ++++++++++++++++
 tb/tb_velocity_table.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/velocity_table.sv
// velocity_table -- per-letter velocity store for the typing game.
//
// Holds ROWS*COLS velocities of VEL_W bits. After reset, or on a reseed
// pulse, an on-chip 16-bit Galois LFSR fills every entry, one per cycle.
// Once the fill is done the table gives a registered read port and a
// write port, and flags out-of-range addresses.
//
// Optional feature macro: VELOCITY_NONZERO_CLAMP_EN
//   When defined, any value that is 0 (from the fill or from a write) is
//   stored as 1, so no letter is ever stationary.
//
// Ports:
//   i_clk       system clock, rising edge
//   i_rst_n     synchronous active-low reset
//   i_row       row index
//   i_col       column index
//   i_wren      write strobe
//   i_data_in   write data
//   i_reseed    one-cycle pulse: refill the table from i_seed_in
//   i_seed_in   fill seed (0 is replaced by 16'hACE1)
//   o_data_out  registered read data
//   o_rd_valid  o_data_out is valid for last cycle's address
//   o_busy      fill sequencer active
//   o_addr_err  one-cycle pulse: last cycle's address was out of range
module velocity_table #(
   parameter int          ROWS  = 1,
   parameter int          COLS  = 53,
   parameter int          VEL_W = 2,
   parameter int          ROW_W = 7,
   parameter int          COL_W = 7,
   parameter logic [15:0] SEED  = 16'hACE1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [ROW_W-1:0] i_row,
   input  logic [COL_W-1:0] i_col,
   input  logic             i_wren,
   input  logic [VEL_W-1:0] i_data_in,
   input  logic             i_reseed,
   input  logic [15:0]      i_seed_in,
   output logic [VEL_W-1:0] o_data_out,
   output logic             o_rd_valid,
   output logic             o_busy,
   output logic             o_addr_err
);

   localparam int DEPTH = ROWS * COLS;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // Wide enough for (2^ROW_W-1)*COLS + (2^COL_W-1) without wrapping.
   localparam int AFW   = ROW_W + COL_W + $clog2(COLS + 1) + 1;

   localparam logic [15:0] DEF_SEED = 16'hACE1;
   localparam logic [15:0] RST_SEED = (SEED == 16'h0000) ? DEF_SEED : SEED;

   localparam logic [0:0] S_FILL  = 1'b0;
   localparam logic [0:0] S_READY = 1'b1;

   function automatic logic [15:0] f_lfsr_next(input logic [15:0] x);
      return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
   endfunction

   function automatic logic [VEL_W-1:0] f_store(input logic [VEL_W-1:0] v);
`ifdef VELOCITY_NONZERO_CLAMP_EN
      return (v == '0) ? VEL_W'(1) : v;
`else
      return v;
`endif
   endfunction

   logic [VEL_W-1:0] r_mem [DEPTH];
   logic [0:0]       r_state;
   logic [15:0]      r_lfsr;
   logic [AW-1:0]    r_fill_addr;

   logic [AFW-1:0]   w_addr_full;
   logic             w_in_range;
   logic [AW-1:0]    w_addr;
   logic [15:0]      w_seed_sel;
   logic             w_we;
   logic [AW-1:0]    w_waddr;
   logic [VEL_W-1:0] w_wdata;

   assign w_addr_full = AFW'(i_row) * AFW'(COLS) + AFW'(i_col);
   assign w_in_range  = (w_addr_full < AFW'(DEPTH));
   assign w_addr      = w_addr_full[AW-1:0];
   assign w_seed_sel  = (i_seed_in == 16'h0000) ? DEF_SEED : i_seed_in;
   assign o_busy      = (r_state == S_FILL);

   // Single memory write port shared by the fill sequencer and i_wren.
   // A reseed suppresses both: the fill restarts and user writes are dropped.
   always_comb begin
      w_we    = 1'b0;
      w_waddr = r_fill_addr;
      w_wdata = f_store(r_lfsr[VEL_W-1:0]);
      if (i_rst_n && !i_reseed) begin
         if (r_state == S_FILL) begin
            w_we = 1'b1;
         end else if (i_wren && w_in_range) begin
            w_we    = 1'b1;
            w_waddr = w_addr;
            w_wdata = f_store(i_data_in);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_we) r_mem[w_waddr] <= w_wdata;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= S_FILL;
         r_lfsr      <= RST_SEED;
         r_fill_addr <= '0;
         o_data_out  <= '0;
         o_rd_valid  <= 1'b0;
         o_addr_err  <= 1'b0;
      end else begin
         case (r_state)
            S_FILL: begin
               o_data_out <= '0;
               o_rd_valid <= 1'b0;
               o_addr_err <= 1'b0;
               if (i_reseed) begin
                  r_lfsr      <= w_seed_sel;
                  r_fill_addr <= '0;
               end else begin
                  r_lfsr <= f_lfsr_next(r_lfsr);
                  if (r_fill_addr == AW'(DEPTH - 1)) begin
                     r_fill_addr <= '0;
                     r_state     <= S_READY;
                  end else begin
                     r_fill_addr <= r_fill_addr + AW'(1);
                  end
               end
            end
            S_READY: begin
               if (i_reseed) begin
                  r_state     <= S_FILL;
                  r_lfsr      <= w_seed_sel;
                  r_fill_addr <= '0;
                  o_data_out  <= '0;
                  o_rd_valid  <= 1'b0;
                  o_addr_err  <= 1'b0;
               end else begin
                  // Read-first: a same-cycle write lands after this sample.
                  o_data_out <= w_in_range ? r_mem[w_addr] : '0;
                  o_rd_valid <= 1'b1;
                  o_addr_err <= !w_in_range;
               end
            end
            default: begin
               r_state     <= S_FILL;
               r_lfsr      <= RST_SEED;
               r_fill_addr <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_velocity_table.sv
// Directed self-checking bench for velocity_table (default parameters).
module tb_velocity_table;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] row, col;
   logic       wren, reseed;
   logic [1:0] data_in;
   logic [15:0] seed_in;
   logic [1:0] data_out;
   logic       rd_valid, busy, addr_err;

   int checks = 0;
   int errors = 0;
   logic [1:0] exp_mem [53];

   always #5 clk = ~clk;

   velocity_table dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_row(row), .i_col(col),
      .i_wren(wren), .i_data_in(data_in), .i_reseed(reseed),
      .i_seed_in(seed_in), .o_data_out(data_out), .o_rd_valid(rd_valid),
      .o_busy(busy), .o_addr_err(addr_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected fill contents for a given seed (Galois LFSR, taps 16'hB400).
   task automatic build_model(input logic [15:0] seed);
      logic [15:0] x;
      logic [1:0]  v;
      x = seed;
      for (int i = 0; i < 53; i++) begin
         v = x[1:0];
`ifdef VELOCITY_NONZERO_CLAMP_EN
         if (v == 2'd0) v = 2'd1;
`endif
         exp_mem[i] = v;
         x = (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
      end
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (busy && n < 200) begin
         tick();
         n++;
      end
   endtask

   task automatic scan(input string tag);
      row = '0;
      wren = 1'b0;
      for (int c = 0; c < 53; c++) begin
         col = 7'(c);
         tick();
         chk($sformatf("%s[%0d]", tag, c), {30'd0, data_out}, {30'd0, exp_mem[c]});
      end
   endtask

   int n;

   initial begin
      rst_n = 1'b0; row = '0; col = '0; wren = 1'b0; reseed = 1'b0;
      data_in = '0; seed_in = '0;

      // Reset state
      tick();
      chk("rst_data_out", data_out, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_addr_err", addr_err, 0);
      chk("rst_busy", busy, 1);

      rst_n = 1'b1;
      count_busy(n);
      chk("fill_busy_cycles", n, 53);
      chk("post_fill_rd_valid", rd_valid, 0);

      // Hand-computed fill values: 0xACE1,0xE270,0x7138,0x389C,0x1C4E,0x0E27,0xB313
      col = 7'd0; tick();
      chk("rd_addr0", data_out, 1);
      chk("rd_valid0", rd_valid, 1);
      col = 7'd1; tick();
`ifdef VELOCITY_NONZERO_CLAMP_EN
      chk("rd_addr1", data_out, 1);
`else
      chk("rd_addr1", data_out, 0);
`endif
      col = 7'd4; tick();
      chk("rd_addr4", data_out, 2);
      col = 7'd6; tick();
      chk("rd_addr6", data_out, 3);
      col = 7'd52; tick();
      chk("rd_addr52_err", addr_err, 0);

      build_model(16'hACE1);
      scan("fill");

      // Write then read back
      col = 7'd10; wren = 1'b1; data_in = 2'd3; tick();
      wren = 1'b0; tick();
      chk("wr10_data", data_out, 3);
      chk("wr10_valid", rd_valid, 1);
      exp_mem[10] = 2'd3;

      // Same-cycle read/write is read-first
      col = 7'd5; wren = 1'b1; data_in = 2'd2; tick();
      chk("rw5_old", data_out, 3);
      wren = 1'b0; tick();
      chk("rw5_new", data_out, 2);
      exp_mem[5] = 2'd2;

      // Out-of-range write: col=53
      col = 7'd53; wren = 1'b1; data_in = 2'd3; tick();
      chk("oor53_err", addr_err, 1);
      chk("oor53_data", data_out, 0);
      chk("oor53_valid", rd_valid, 1);
      wren = 1'b0; col = 7'd0; tick();
      chk("oor_err_pulse", addr_err, 0);
      // row=1,col=0 also maps to address 53
      row = 7'd1; col = 7'd0; tick();
      chk("oor_row1_err", addr_err, 1);
      scan("after_oor");

      // Reseed with seed 0 from READY; a write during busy must be ignored
      seed_in = 16'h0000; reseed = 1'b1; tick();
      reseed = 1'b0;
      chk("reseed_busy", busy, 1);
      chk("reseed_rd_valid", rd_valid, 0);
      n = 0;
      while (busy && n < 200) begin
         if (n == 30) begin wren = 1'b1; col = 7'd7; data_in = 2'd2; end
         else wren = 1'b0;
         tick();
         n++;
         if (n == 10) begin
            chk("busy_rd_valid", rd_valid, 0);
            chk("busy_data_out", data_out, 0);
            chk("busy_addr_err", addr_err, 0);
         end
      end
      wren = 1'b0;
      chk("reseed_busy_cycles", n, 53);
      build_model(16'hACE1);
      scan("reseed0");

      // Reseed twice; the second (seed 0) wins and restarts the count
      seed_in = 16'h1234; reseed = 1'b1; tick();
      reseed = 1'b0;
      repeat (20) tick();
      seed_in = 16'h0000; reseed = 1'b1; tick();
      reseed = 1'b0;
      count_busy(n);
      chk("reseed2_busy_cycles", n, 53);
      scan("reseed2");

      // Reset mid-fill restarts from SEED
      seed_in = 16'h1234; reseed = 1'b1; tick();
      reseed = 1'b0;
      repeat (10) tick();
      rst_n = 1'b0; tick();
      chk("midfill_rst_busy", busy, 1);
      rst_n = 1'b1;
      count_busy(n);
      chk("midfill_busy_cycles", n, 53);
      scan("midfill_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
